i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters sharing one i2c_ctrl.
REQ-002 SHALL have parameter LEN_W, default 4, width of per-request byte count.
REQ-003 SHALL have parameter TIMEOUT, default 1024, clk cycles allowed for ctrl_busy to rise after start.
REQ-004 SHALL have clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have req_valid  in  NREQ  per-requester transaction request, level, held until done.
REQ-007 SHALL have req_addr  in  NREQ*8  per-requester 7-bit address plus R/W in bit 0 (1 = read).
REQ-008 SHALL have req_len  in  NREQ*LEN_W  per-requester data byte count.
REQ-009 SHALL have req_wdata  in  NREQ*8  per-requester current write byte.
REQ-010 SHALL have grant  out  NREQ  one-hot owner of the ctrl; all-zero when idle.
REQ-011 SHALL have wr_next  out  1  pulse: granted requester advances req_wdata to the next byte.
REQ-012 SHALL have rd_data / rd_valid  out  8 / 1  received byte, with single-cycle qualifier.
REQ-013 SHALL have done / err  out  1 / 1  transaction-end pulse; err qualifies done.
REQ-014 SHALL have ctrl_feed_n / ctrl_addr / ctrl_wdata  out  1 / 8 / 8  drive of i2c_ctrl feed, addr, write data.
REQ-015 SHALL have ctrl_busy / ctrl_byte_done / ctrl_rdata  in  1 / 1 / 8  ctrl activity, one-cycle pulse at end of each data-byte ack, read byte.

Function
REQ-016 SHALL implement the states IDLE, START, XFER, STOP, DONE.
REQ-017 IDLE: grant zero, ctrl_feed_n=1; any req_valid -> pick a winner round-robin starting after the last winner, latch its addr/len, go to START next cycle.
REQ-018 req_len=0 at grant SHALL go directly to DONE with err=1, without driving ctrl_feed_n low.
REQ-019 START: ctrl_feed_n=0; ctrl_busy=1 -> XFER; TIMEOUT cycles without busy -> DONE, err=1.
REQ-020 XFER: remaining count is loaded with len; ctrl_feed_n=0 while remaining>1, 1 when remaining==1, so the ctrl stops after the last byte.
REQ-021 On each ctrl_byte_done in XFER, remaining SHALL decrement. Write: pulse wr_next the same cycle. Read: register ctrl_rdata to rd_data and pulse rd_valid the next cycle.
REQ-022 remaining reaching 0 -> STOP.
REQ-023 ctrl_busy falling in XFER with remaining>0 (NACK) -> DONE, err=1.
REQ-024 STOP: ctrl_feed_n=1; wait for ctrl_busy=0 -> DONE.
REQ-025 DONE: done=1 for exactly one cycle, grant still asserted that cycle; then IDLE. err is valid only with done.
REQ-026 ctrl_addr and ctrl_wdata SHALL be the muxed req_addr and req_wdata of the granted requester; both are 0 when idle.
REQ-027 Deassertion of req_valid by the owner mid-transaction SHALL be ignored; the transaction completes.
REQ-028 A simultaneous ctrl_byte_done and busy fall SHALL count the byte before the NACK check.
REQ-029 A requester SHALL never be granted twice in a row while another requester is valid.

Reset
REQ-030 rst SHALL force IDLE, grant=0, ctrl_feed_n=1, done=err=rd_valid=wr_next=0, rd_data=0, counters 0, last-winner=NREQ-1, so requester 0 wins first.
REQ-031 rst mid-transaction SHALL release ctrl_feed_n high in the next cycle; the ctrl then finishes with a STOP on its own.

Structure
REQ-032 The state enum and the err encoding SHALL live in shared package i2c_pkg.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (req, last, grant one-hot), purely combinational except the last-winner register in the parent.

Verification
REQ-034 Req0 write, addr 0x42, len 2, bytes 0xA5,0x5A, model ACKs -> two wr_next pulses, feed_n high after first byte_done, done=1 err=0.
REQ-035 Req1 read, addr 0x43, len 3, rdata 0x11,0x22,0x33 -> rd_valid x3 with those values in order, done err=0.
REQ-036 req_valid=2'b11 held across three transactions -> grants 01,10,01.
REQ-037 Model never raises busy -> done err=1 at cycle TIMEOUT+2 after grant, feed_n back high.
REQ-038 Write len 4, model drops busy after byte 2 -> done err=1, exactly 2 wr_next; len=0 request -> done err=1, feed_n never low.
REQ-039 rst asserted during XFER -> all outputs at reset values the next cycle, and a following req0 is granted first.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types for the i2c requester arbiter: FSM states and the
// transaction-error encoding reported through done/err.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StXfer,
    StStop,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ErrNone,
    ErrLen0,
    ErrTimeout,
    ErrNack
  } err_e;

  function automatic logic err_flag(input err_e e);
    return e != ErrNone;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches req_i starting one past last_i
// and returns a one-hot grant (all-zero when nothing is requested).
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] last_i,
  output logic [NREQ-1:0] grant_o
);

  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = IdxW'((32'(last_i) + off) % NREQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one i2c_ctrl between NREQ requesters: round-robin grant, byte
// counting, read capture, write-data advance, timeout and NACK handling.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*8-1:0]       req_addr_i,
  input  logic [NREQ*LEN_W-1:0]   req_len_i,
  input  logic [NREQ*8-1:0]       req_wdata_i,
  output logic [NREQ-1:0]         grant_o,
  output logic                    wr_next_o,
  output logic [7:0]              rd_data_o,
  output logic                    rd_valid_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    ctrl_feed_n_o,
  output logic [7:0]              ctrl_addr_o,
  output logic [7:0]              ctrl_wdata_o,
  input  logic                    ctrl_busy_i,
  input  logic                    ctrl_byte_done_i,
  input  logic [7:0]              ctrl_rdata_i
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam logic [IdxW-1:0] LastRst = IdxW'(NREQ - 1);
  localparam logic [TmrW-1:0] TmrMax  = TmrW'(TIMEOUT);

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  logic [NREQ-1:0]   grant_q, grant_d, rr_grant;
  logic [IdxW-1:0]   last_q, last_d, win_idx;
  logic              rw_q, rw_d;
  logic [LEN_W-1:0]  len_q, len_d, rem_q, rem_d, rem_nxt, sel_len;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [7:0]        rd_data_q, rd_data_d, sel_addr;
  logic              rd_valid_q, rd_valid_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr (
    .req_i   (req_valid_i),
    .last_i  (last_q),
    .grant_o (rr_grant)
  );

  // Fields of the requester that would win this cycle's arbitration
  always_comb begin
    win_idx  = '0;
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_grant[i]) begin
        win_idx  = IdxW'(i);
        sel_addr = req_addr_i[i*8 +: 8];
        sel_len  = req_len_i[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    ctrl_addr_o  = '0;
    ctrl_wdata_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        ctrl_addr_o  = req_addr_i[i*8 +: 8];
        ctrl_wdata_o = req_wdata_i[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    grant_d       = grant_q;
    last_d        = last_q;
    rw_d          = rw_q;
    len_d         = len_q;
    rem_d         = rem_q;
    tmr_d         = tmr_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    rem_nxt       = rem_q;
    ctrl_feed_n_o = 1'b1;
    wr_next_o     = 1'b0;
    done_o        = 1'b0;

    case (state_q)
      StIdle: begin
        err_d = ErrNone;
        tmr_d = '0;
        if (|req_valid_i) begin
          grant_d = rr_grant;
          last_d  = win_idx;
          rw_d    = sel_addr[0];
          len_d   = sel_len;
          if (sel_len == '0) begin
            err_d   = ErrLen0;
            state_d = StDone;
          end else begin
            state_d = StStart;
          end
        end
      end

      StStart: begin
        ctrl_feed_n_o = 1'b0;
        if (ctrl_busy_i) begin
          rem_d   = len_q;
          state_d = StXfer;
        end else if (tmr_q == TmrMax) begin
          err_d   = ErrTimeout;
          state_d = StDone;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end

      StXfer: begin
        // Raise feed_n during the last byte so the ctrl issues STOP after it
        ctrl_feed_n_o = !(rem_q > LEN_W'(1));
        rem_nxt       = rem_q - LEN_W'(ctrl_byte_done_i);
        if (ctrl_byte_done_i) begin
          rem_d = rem_nxt;
          if (rw_q) begin
            rd_data_d  = ctrl_rdata_i;
            rd_valid_d = 1'b1;
          end else begin
            wr_next_o = 1'b1;
          end
        end
        // Byte is counted first, so a final byte coinciding with busy low is not a NACK
        if (rem_nxt == '0) begin
          state_d = StStop;
        end else if (!ctrl_busy_i) begin
          err_d   = ErrNack;
          state_d = StDone;
        end
      end

      StStop: begin
        if (!ctrl_busy_i) state_d = StDone;
      end

      StDone: begin
        done_o  = 1'b1;
        grant_d = '0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    err_o = done_o && err_flag(err_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      err_q      <= ErrNone;
      grant_q    <= '0;
      last_q     <= LastRst;
      rw_q       <= 1'b0;
      len_q      <= '0;
      rem_q      <= '0;
      tmr_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      rw_q       <= rw_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      tmr_q      <= tmr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign grant_o    = grant_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: behavioural i2c_ctrl model, scoreboard queues for
// write bytes, read bytes and done/err/grant, plus directed scenarios.
module tb_i2c_arbiter;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned TIMEOUT = 16;

  localparam int MIdle = 0;
  localparam int MByte = 1;
  localparam int MStop = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [7:0]            addr0 = '0, addr1 = '0;
  logic [LEN_W-1:0]      len0 = '0, len1 = '0;
  logic [7:0]            wdata1 = '0;
  logic [7:0]            wr_tab [4];
  logic [1:0]            wr_idx = '0;
  bit                    wr_adv = 1'b0;
  logic [NREQ*8-1:0]     req_addr, req_wdata;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       grant;
  logic                  wr_next, rd_valid, done, err, feed_n;
  logic [7:0]            rd_data, ctrl_addr, ctrl_wdata;
  logic                  ctrl_busy = 1'b0, ctrl_byte_done = 1'b0;
  logic [7:0]            ctrl_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [NREQ:0] exp_done [$];

  int wr_cnt = 0, rd_cnt = 0, feed_low_cnt = 0;

  // ctrl model configuration: 0 ack, 1 never busy, 2 nack after m_nack bytes
  int         m_mode = 0, m_nack = 0, m_st = MIdle, m_gap = 0, m_cnt = 0;
  logic [7:0] m_rd [4];

  assign req_addr  = {addr1, addr0};
  assign req_len   = {len1, len0};
  assign req_wdata = {wdata1, wr_tab[wr_idx]};

  always #5 clk = ~clk;

  i2c_arbiter #(
    .NREQ    (NREQ),
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_addr_i       (req_addr),
    .req_len_i        (req_len),
    .req_wdata_i      (req_wdata),
    .grant_o          (grant),
    .wr_next_o        (wr_next),
    .rd_data_o        (rd_data),
    .rd_valid_o       (rd_valid),
    .done_o           (done),
    .err_o            (err),
    .ctrl_feed_n_o    (feed_n),
    .ctrl_addr_o      (ctrl_addr),
    .ctrl_wdata_o     (ctrl_wdata),
    .ctrl_busy_i      (ctrl_busy),
    .ctrl_byte_done_i (ctrl_byte_done),
    .ctrl_rdata_i     (ctrl_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk); #1;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_grant"}, 32'(grant), 0);
    check({pfx, "_feed_n"}, 32'(feed_n), 1);
    check({pfx, "_done"}, 32'(done), 0);
    check({pfx, "_err"}, 32'(err), 0);
    check({pfx, "_rd_valid"}, 32'(rd_valid), 0);
    check({pfx, "_wr_next"}, 32'(wr_next), 0);
    check({pfx, "_rd_data"}, 32'(rd_data), 0);
    check({pfx, "_ctrl_addr"}, 32'(ctrl_addr), 0);
  endtask

  // Behavioural i2c_ctrl: samples feed_n at the end of each byte to continue or stop
  always @(negedge clk) begin
    ctrl_byte_done = 1'b0;
    case (m_st)
      MIdle: if (feed_n === 1'b0 && m_mode != 1) begin
        ctrl_busy = 1'b1;
        m_cnt     = 0;
        m_gap     = 2;
        m_st      = MByte;
      end
      MByte: if (m_gap > 0) begin
        m_gap--;
      end else begin
        ctrl_byte_done = 1'b1;
        ctrl_rdata     = (m_cnt < 4) ? m_rd[m_cnt] : 8'h00;
        m_cnt++;
        if (m_mode == 2 && m_cnt == m_nack) begin
          ctrl_busy = 1'b0;
          m_st      = MIdle;
        end else if (feed_n === 1'b1) begin
          m_gap = 2;
          m_st  = MStop;
        end else begin
          m_gap = 2;
        end
      end
      MStop: if (m_gap > 0) begin
        m_gap--;
      end else begin
        ctrl_busy = 1'b0;
        m_st      = MIdle;
      end
      default: m_st = MIdle;
    endcase
  end

  // Output monitor and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    #1;
    if (feed_n === 1'b0) feed_low_cnt++;
    if (wr_next === 1'b1) begin
      wr_cnt++;
      check("wr_expected", 32'(exp_wr.size() != 0), 1);
      if (exp_wr.size() != 0) check("wr_byte", 32'(ctrl_wdata), 32'(exp_wr.pop_front()));
      if (wr_adv && grant[0]) wr_idx++;
    end
    if (rd_valid === 1'b1) begin
      rd_cnt++;
      check("rd_expected", 32'(exp_rd.size() != 0), 1);
      if (exp_rd.size() != 0) check("rd_byte", 32'(rd_data), 32'(exp_rd.pop_front()));
    end
    if (done === 1'b1) begin
      check("done_expected", 32'(exp_done.size() != 0), 1);
      if (exp_done.size() != 0) check("done_grant_err", 32'({grant, err}), 32'(exp_done.pop_front()));
      wr_idx = '0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1);
  end

  initial begin
    int  c;
    int  snap;
    bit  ok;
    for (int i = 0; i < 4; i++) begin
      wr_tab[i] = '0;
      m_rd[i]   = '0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;

    // Req0 write 0x42, two bytes
    addr0 = 8'h42; len0 = 4'd2; wr_tab[0] = 8'hA5; wr_tab[1] = 8'h5A; wr_adv = 1'b1;
    exp_wr.push_back(8'hA5); exp_wr.push_back(8'h5A);
    exp_done.push_back({2'b01, 1'b0});
    snap = wr_cnt;
    req_valid = 2'b01;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (wr_next === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("a_first_wr", 32'(ok), 1);
    @(negedge clk); #1;
    check("a_feed_after_first", 32'(feed_n), 1);
    wait_done("a_done", 40);
    req_valid = '0;
    check("a_wr_count", 32'(wr_cnt - snap), 2);
    wr_adv = 1'b0;

    // Req1 read 0x43, three bytes
    @(negedge clk);
    addr1 = 8'h43; len1 = 4'd3;
    m_rd[0] = 8'h11; m_rd[1] = 8'h22; m_rd[2] = 8'h33;
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
    exp_done.push_back({2'b10, 1'b0});
    snap = rd_cnt;
    req_valid = 2'b10;
    wait_done("b_done", 60);
    req_valid = '0;
    check("b_rd_count", 32'(rd_cnt - snap), 3);

    // Both requesting across three transactions: 01, 10, 01
    @(negedge clk);
    addr0 = 8'h42; len0 = 4'd1; wr_tab[0] = 8'h10;
    addr1 = 8'h44; len1 = 4'd1; wdata1 = 8'h20;
    exp_wr.push_back(8'h10); exp_wr.push_back(8'h20); exp_wr.push_back(8'h10);
    exp_done.push_back({2'b01, 1'b0});
    exp_done.push_back({2'b10, 1'b0});
    exp_done.push_back({2'b01, 1'b0});
    req_valid = 2'b11;
    wait_done("c_done0", 40);
    wait_done("c_done1", 40);
    wait_done("c_done2", 40);
    req_valid = '0;

    // Ctrl never goes busy: timeout
    @(negedge clk);
    m_mode = 1;
    addr0 = 8'h50; len0 = 4'd1;
    exp_done.push_back({2'b01, 1'b1});
    req_valid = 2'b01;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (grant !== '0) begin
        ok = 1'b1;
        break;
      end
    end
    check("d_grant", 32'(ok), 1);
    check("d_feed_start", 32'(feed_n), 0);
    c  = 1;
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT + 10; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
      c++;
    end
    req_valid = '0;
    check("d_done", 32'(ok), 1);
    check("d_cycle", 32'(c), TIMEOUT + 2);
    @(negedge clk); #1;
    check("d_feed_after", 32'(feed_n), 1);

    // NACK after byte 2 of a four-byte write
    @(negedge clk);
    m_mode = 2; m_nack = 2;
    addr1 = 8'h46; len1 = 4'd4; wdata1 = 8'h77;
    exp_wr.push_back(8'h77); exp_wr.push_back(8'h77);
    exp_done.push_back({2'b10, 1'b1});
    snap = wr_cnt;
    req_valid = 2'b10;
    wait_done("e_done", 60);
    req_valid = '0;
    check("e_wr_count", 32'(wr_cnt - snap), 2);

    // Zero-length request
    @(negedge clk);
    m_mode = 0;
    len0 = 4'd0;
    exp_done.push_back({2'b01, 1'b1});
    snap = feed_low_cnt;
    req_valid = 2'b01;
    wait_done("f_done", 10);
    req_valid = '0;
    @(negedge clk); #1;
    check("f_feed_never_low", 32'(feed_low_cnt - snap), 0);

    // Reset during a read transfer
    @(negedge clk);
    addr0 = 8'h49; len0 = 4'd3;
    m_rd[0] = 8'hC1; m_rd[1] = 8'hC2; m_rd[2] = 8'hC3;
    exp_rd.push_back(8'hC1); exp_rd.push_back(8'hC2); exp_rd.push_back(8'hC3);
    snap = rd_cnt;
    req_valid = 2'b01;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (rd_cnt != snap) begin
        ok = 1'b1;
        break;
      end
    end
    check("g_first_rd", 32'(ok), 1);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk); #1;
    check_reset_outputs("g_rst");
    exp_rd.delete();
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_st == MIdle && ctrl_busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("g_ctrl_idle", 32'(ok), 1);
    addr0 = 8'h4A; len0 = 4'd1; wr_tab[0] = 8'h31;
    addr1 = 8'h4C; len1 = 4'd1; wdata1 = 8'h32;
    exp_wr.push_back(8'h31);
    exp_done.push_back({2'b01, 1'b0});
    req_valid = 2'b11;
    wait_done("g_done", 40);
    req_valid = '0;

    repeat (3) @(negedge clk);
    #1;
    check("end_exp_wr_empty", 32'(exp_wr.size()), 0);
    check("end_exp_rd_empty", 32'(exp_rd.size()), 0);
    check("end_exp_done_empty", 32'(exp_done.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
